// File: rtl/display_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_pkg
//  Description : Shared constants and a helper function for the multiplexed
//                eight-digit hex display scanner. The package contains:
//                  c_NUM_DIGITS - number of scanned digits (8)
//                  c_NIBBLE_W   - width of one hex digit (4)
//                  c_VALUE_W    - width of the full display word (32)
//                  c_IDX_W      - width of the digit index (3)
//                  c_LAST_IDX   - index of the last digit in a frame
//                  c_SEL_RESET  - digit_sel value while in reset (digit 0 on)
//                  onecold_sel  - active-low one-hot select for a digit index
//  Revision    : 1.0 - initial release
// ============================================================================
package display_scan_pkg;

    localparam int unsigned c_NUM_DIGITS = 8;
    localparam int unsigned c_NIBBLE_W   = 4;
    localparam int unsigned c_VALUE_W    = 32;
    localparam int unsigned c_IDX_W      = 3;

    localparam logic [c_IDX_W-1:0]      c_LAST_IDX  = 3'd7;
    localparam logic [c_NUM_DIGITS-1:0] c_SEL_RESET = 8'hFE;

    // Active-low digit enable: every bit high except the selected digit.
    function automatic logic [c_NUM_DIGITS-1:0] onecold_sel(
        input logic [c_IDX_W-1:0] idx
    );
        logic [c_NUM_DIGITS-1:0] sel;
        sel      = '1;
        sel[idx] = 1'b0;
        return sel;
    endfunction

endpackage : display_scan_pkg
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Free-running prescaler for the display scanner. The counter
//                runs 0..DIV-1 and wraps; o_tick is high for the single cycle
//                in which the counter sits at DIV-1, so the digit index
//                advances once every DIV clocks.
//  Ports       : clk    - rising-edge clock
//                rst    - synchronous active-high reset (counter to 0)
//                o_tick - one-cycle-in-DIV advance strobe (combinational)
//  Parameters  : DIV    - clocks per digit, legal range 2..65535
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    // 16 bits covers the full legal DIV range.
    localparam int unsigned          c_PCNT_W = 16;
    localparam logic [c_PCNT_W-1:0]  c_LAST   = c_PCNT_W'(DIV - 1);
    localparam logic [c_PCNT_W-1:0]  c_ONE    = c_PCNT_W'(1);

    logic [c_PCNT_W-1:0] r_pcnt;
    logic                w_at_last;

    assign w_at_last = (r_pcnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_at_last) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + c_ONE;
        end
    end

    assign o_tick = w_at_last;

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan
//  Description : Time-multiplexed scanner for an eight-digit hex display.
//                A 32-bit value is captured into a shadow register on load
//                and promoted to the display register only at the frame wrap
//                (digit 7 -> digit 0), so a frame is never torn. Each digit
//                is held for DIV clocks; the select and data outputs are
//                registered and trail the digit index by one cycle.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset
//                load       - single-cycle strobe capturing value
//                value      - eight hex nibbles, nibble 0 = bits 3:0
//                digit_data - nibble for the downstream segment decoder
//                digit_sel  - one-cold active-low digit enable
//                frame_done - one-cycle pulse after each 8-digit frame
//  Parameters  : DIV        - clocks each digit is held (2..65535)
//  Options     : LEADING_ZERO_BLANK_EN - when defined, slots above the most
//                significant non-zero nibble are blanked (digit_sel = 8'hFF);
//                digit 0 is always lit. Undefined: all digits always lit.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan
    import display_scan_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [c_VALUE_W-1:0]    value,
    output logic [c_NIBBLE_W-1:0]   digit_data,
    output logic [c_NUM_DIGITS-1:0] digit_sel,
    output logic                    frame_done
);

    // ------------------------------------------------------------------
    // Digit-rate strobe
    // ------------------------------------------------------------------
    logic w_tick;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_pending;
    logic [c_VALUE_W-1:0]    r_shadow;
    logic [c_VALUE_W-1:0]    r_display;
    logic [c_NIBBLE_W-1:0]   r_digit_data;
    logic [c_NUM_DIGITS-1:0] r_digit_sel;
    logic                    r_frame_done;

    // The last tick of digit 7 closes the frame; this is the only point at
    // which the display register may change.
    logic w_wrap;
    assign w_wrap = w_tick && (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------
    // Next digit select (optionally with leading-zero blanking)
    // ------------------------------------------------------------------
    logic [c_NUM_DIGITS-1:0] w_sel_next;

`ifdef LEADING_ZERO_BLANK_EN
    // w_blank[k] is set when every nibble from k up to 7 is zero, i.e. the
    // slot holds a leading zero. Slot 0 is excluded so a zero value still
    // shows a single "0".
    logic [c_NUM_DIGITS-1:0] w_blank;

    assign w_blank[0] = 1'b0;

    for (genvar k = 1; k < c_NUM_DIGITS; k++) begin : g_blank
        assign w_blank[k] = ~|r_display[c_VALUE_W-1 : k*c_NIBBLE_W];
    end

    assign w_sel_next = w_blank[r_idx] ? '1 : onecold_sel(r_idx);
`else
    assign w_sel_next = onecold_sel(r_idx);
`endif

    // ------------------------------------------------------------------
    // Scanner
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_shadow     <= '0;
            r_display    <= '0;
            r_digit_data <= '0;
            r_digit_sel  <= c_SEL_RESET;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;

            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end

            // Promotion uses the shadow as it was before this edge, so a
            // load coinciding with the wrap is held back one more frame.
            if (w_wrap && r_pending) begin
                r_display <= r_shadow;
            end

            // A load always leaves a pending value behind, even on the wrap;
            // otherwise the wrap consumes the pending flag.
            if (load) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end

            // Outputs follow the index one cycle later. At the wrap the
            // display register and the index change on the same edge, so
            // digit 0 of the new frame already reads the promoted value.
            r_digit_sel  <= w_sel_next;
            r_digit_data <= r_display[{r_idx, 2'b00} +: c_NIBBLE_W];
        end
    end

    assign digit_data = r_digit_data;
    assign digit_sel  = r_digit_sel;
    assign frame_done = r_frame_done;

endmodule : display_scan
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan
//  Description : Scoreboard bench for display_scan with DIV=4. A reference
//                process derives the expected outputs for every clock from
//                the elapsed cycle count since reset (digit slot, frame
//                boundary) and a frame-level model of the shadow/display
//                values, and queues them; an independent monitor pops and
//                compares against the DUT on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] value;
    logic [3:0]  digit_data;
    logic [7:0]  digit_sel;
    logic        frame_done;

    display_scan #(
        .DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .digit_data (digit_data),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic [3:0] data;
        logic       fd;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_n = 0;      // clock edges since reset released
    logic [31:0] m_disp = '0;  // value currently on the display
    logic [31:0] m_shadow = '0;
    bit          m_pend = 0;

    // ------------------------------------------------------------------
    // Reference: one expected output per clock edge
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        int   slot;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_n      = 0;
                m_disp   = '0;
                m_shadow = '0;
                m_pend   = 0;
                e        = {8'hFE, 4'h0, 1'b0};
            end else begin
                // The slot shown after this edge is the digit that was
                // active during the cycle before it.
                slot   = (m_n / DIV) % 8;
                e.data = m_disp[slot*4 +: 4];
                e.sel  = 8'hFF;
                e.sel[slot] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                if (slot > 0 && (m_disp >> (4 * slot)) == 32'd0) begin
                    e.sel = 8'hFF;
                end
`endif
                e.fd = ((m_n % FRAME) == (FRAME - 1));
                if (e.fd && m_pend) begin
                    m_disp = m_shadow;
                    m_pend = 0;
                end
                if (load) begin
                    m_shadow = value;
                    m_pend   = 1;
                end
                m_n++;
            end
            q.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (digit_sel !== e.sel) begin
                    errors++;
                    $display("FAIL digit_sel t=%0t got=%h exp=%h", $time, digit_sel, e.sel);
                end
                checks++;
                if (digit_data !== e.data) begin
                    errors++;
                    $display("FAIL digit_data t=%0t got=%h exp=%h", $time, digit_data, e.data);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL frame_done t=%0t got=%b exp=%b", $time, frame_done, e.fd);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic l, input logic [31:0] v);
        rst   = r;
        load  = l;
        value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    // Advance until the next edge is edge number k within a frame.
    task automatic wait_pos(input int k);
        int guard;
        guard = 0;
        while ((m_n % FRAME) != k && guard < 2 * FRAME) begin
            step(1'b0, 1'b0, 32'h0);
            guard++;
        end
        if (guard >= 2 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL wait_pos k=%0d got=%0d exp=%0d", k, m_n % FRAME, k);
        end
    endtask

    initial begin
        logic [31:0] v;
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);

        // Plain scan of a zero display
        idle(40);

        // Mid-frame load
        wait_pos(10);
        step(1'b0, 1'b1, 32'h1234_ABCD);
        idle(80);

        // Two loads in one frame: the second wins
        wait_pos(3);
        step(1'b0, 1'b1, 32'h1111_1111);
        idle(5);
        step(1'b0, 1'b1, 32'h2222_2222);
        idle(80);

        // Load on the wrap edge with nothing pending
        wait_pos(FRAME - 1);
        step(1'b0, 1'b1, 32'h0000_00A0);
        idle(80);

        // Load on the wrap edge with a value already pending
        wait_pos(20);
        step(1'b0, 1'b1, 32'h5A5A_0F0F);
        wait_pos(FRAME - 1);
        step(1'b0, 1'b1, 32'h0000_0300);
        idle(80);

        // Zero value
        step(1'b0, 1'b1, 32'h0);
        idle(70);

        // Reset at idx=5 with a load pending
        step(1'b0, 1'b1, 32'h7654_3210);
        idle(70);
        wait_pos(16);
        step(1'b0, 1'b1, 32'hDEAD_BEEF);
        wait_pos(5 * DIV + 1);
        step(1'b1, 1'b0, 32'h0);
        idle(80);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            v = $urandom >> (4 * $urandom_range(0, 8));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), v);
        end
        idle(4);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_display_scan
`default_nettype wire

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DIV, default 50000: clk cycles each digit is held; legal range 2..65535.
REQ-002 Port list, in order:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe that captures value.
- value  input  32  eight hex nibbles; nibble 0 = bits 3:0.
- digit_data  output  4  nibble for the downstream segment decoder.
- digit_sel  output  8  one-cold digit enable, active-low; bit k selects digit k.
- frame_done  output  1  one-cycle pulse at the end of each 8-digit frame.
REQ-003 The block has one clock; reset is synchronous and active-high.

Function
REQ-004 Prescaler pcnt counts 0..DIV-1 and wraps to 0; tick is asserted when pcnt==DIV-1.
REQ-005 Digit index idx (3 bits) increments on tick; it wraps from 7 to 0.
REQ-006 On a tick with idx==7 (the wrap), frame_done is 1 in the following cycle only.
REQ-007 When load=1, value is written to the shadow register and pending is set.
REQ-008 At the wrap, if pending=1, shadow is copied to the display register and pending is cleared; the display register never changes mid-frame.
REQ-009 If load and the wrap occur in the same cycle:
- the new value goes to shadow and pending stays 1;
- the display register takes the prior shadow if pending was already 1, and is unchanged otherwise.
REQ-010 digit_sel and digit_data are registered and update one cycle after idx changes:
- digit_sel = ~(1<<idx);
- digit_data = display[4*idx+3 : 4*idx].
REQ-011 Latency from load to the first displayed digit of the new value: at most 8*DIV+2 cycles.
REQ-012 Repeated loads within one frame: the last one wins; earlier values are never shown.
REQ-013 Exactly one digit_sel bit is low at all times, except when the slot is blanked (REQ-016).

Reset
REQ-014 While rst=1 at a clock edge, the block takes these values:
- pcnt=0, idx=0, pending=0;
- shadow and display registers = 0;
- digit_sel=8'hFE, digit_data=0, frame_done=0.
REQ-015 rst asserted mid-frame aborts the frame without a frame_done pulse; any pending load is discarded.

Configuration
REQ-016 With LEADING_ZERO_BLANK_EN defined, blanking is enabled:
- slot k>0 drives digit_sel=8'hFF when display nibbles 7..k are all zero;
- digit 0 is never blanked;
- digit_data still carries the nibble.
Without the macro, all eight digits are always enabled.

Structure
REQ-017 A shared package holds:
- NUM_DIGITS=8;
- the width constants 4 and 32;
- the reset digit_sel constant 8'hFE.
REQ-018 One sub-module is used: scan_prescaler, which holds pcnt and produces tick. All other logic is in display_scan.

Verification
REQ-019 DIV=4; rst for 2 cycles, then release. Required response:
- digit_sel steps FE,FD,FB,...,7F, each held 4 cycles;
- frame_done pulses once every 32 cycles.
REQ-020 load with value=32'h1234_ABCD mid-frame. Required response:
- the current frame keeps showing the old value;
- from the next frame, digit 0..7 show D,C,B,A,4,3,2,1.
REQ-021 load 32'h1111_1111 then 32'h2222_2222 within one frame. Required response: only 2 appears in the next frame; 1 is never shown.
REQ-022 load asserted in the same cycle as the wrap tick. Required response: the value appears one frame later, as REQ-009 defines.
REQ-023 rst asserted at idx=5. Required response:
- the next cycle has digit_sel=FE and digit_data=0;
- no frame_done pulse occurs;
- the pending value is discarded.
REQ-024 With LEADING_ZERO_BLANK_EN defined, value=32'h0000_00A0. Required response:
- slots 0..1 are enabled, showing 0 and A;
- slots 2..7 drive digit_sel=FF;
- value=0 lights only digit 0.
